// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: groups the CPU, loader and RAM-facing signals of the RAM arbiter.
// The slave modport is the arbiter's view. The master modport is the view of its
// surroundings: the CPU control unit, the program loader and the RAM.
interface ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  // CPU datapath side
  logic              cpu_t0;
  logic              cpu_hlt;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ram_in;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;

  // Program loader side
  logic              ldr_req;
  logic              ldr_valid;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  // RAM side (asynchronous read, write on the arbiter's clock edge)
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Sticky protocol error flag
  logic              arb_err;

  modport slave (
    input  cpu_t0, cpu_hlt, cpu_addr, cpu_ram_in, cpu_wdata,
    output cpu_stall,
    input  ldr_req, ldr_valid, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_ack, ldr_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata,
    output arb_err
  );

  modport master (
    output cpu_t0, cpu_hlt, cpu_addr, cpu_ram_in, cpu_wdata,
    input  cpu_stall,
    output ldr_req, ldr_valid, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_ack, ldr_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata,
    input  arb_err
  );

endinterface : ram_arbiter_if

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single program/data RAM between the CPU datapath and an
// external program loader.
//
// Behaviour:
// - The CPU normally owns the RAM.
// - A loader request freezes the CPU at an instruction boundary (T0), then grants
//   the loader a burst of read/write beats.
// - The RAM is then handed back to the CPU.
//
// All state advances on the falling clock edge, the same edge the control unit uses.
//
// Optional feature: define RAM_ARB_ERR_EN to build the sticky protocol checker
// behind arb_err. Without it, arb_err is tied low.
module ram_arbiter #(
  parameter int ADDR_W    = 4,  // RAM address width (MAR width)
  parameter int DATA_W    = 8,  // RAM data width
  parameter int MAX_BURST = 4   // loader beats per grant before forced release, >= 1
) (
  input logic            clock,  // state advances on negedge
  input logic            clear,  // asynchronous active-low reset
  ram_arbiter_if.slave   bus
);

  // Arbiter states
  localparam logic [1:0] S_CPU   = 2'd0;  // CPU owns the RAM
  localparam logic [1:0] S_DRAIN = 2'd1;  // CPU stalled, waiting for its instruction boundary
  localparam logic [1:0] S_LDR   = 2'd2;  // loader owns the RAM
  localparam logic [1:0] S_TURN  = 2'd3;  // one idle cycle while ownership returns to the CPU

  // The burst counter saturates at MAX_BURST, so it needs exactly this many bits.
  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  // State and output registers
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic              r_fair;     // CPU must run one instruction before the next grant
  logic              r_forced;   // the current S_LDR exit was caused by the beat limit
  logic              r_stall;
  logic              r_gnt;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  // Combinational helpers
  logic [1:0]        w_next;
  logic              w_beat;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_limit;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_wdata;

  // Beats count only while the loader owns the RAM. Anything presented earlier is dropped.
  assign w_beat     = (r_state == S_LDR) && bus.ldr_valid;
  assign w_cnt_inc  = (r_burst_cnt == MAX_CNT) ? r_burst_cnt : r_burst_cnt + CNT_W'(1);
  assign w_cnt_next = w_beat ? w_cnt_inc : r_burst_cnt;
  // The beat that reaches the limit still completes, and the exit happens on the same
  // edge. While the CPU is halted it has nothing to run, so bursts are never cut short.
  assign w_limit    = (w_cnt_next == MAX_CNT) && !bus.cpu_hlt;

  // Next-state decode for the ownership FSM
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no path through the case statement can infer a latch.
    w_next = r_state;
    case (r_state)
      S_CPU: begin
        if (bus.ldr_req && !r_fair) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.ldr_req) begin
          w_next = S_CPU;
        end else if (bus.cpu_t0 || bus.cpu_hlt) begin
          w_next = S_LDR;
        end
      end
      S_LDR: begin
        if (!bus.ldr_req || w_limit) begin
          w_next = S_TURN;
        end
      end
      S_TURN: begin
        w_next = S_CPU;
      end
      default: begin
        w_next = S_CPU;
      end
    endcase
  end

  // RAM port mux.
  // - S_CPU and S_DRAIN: the CPU drives the RAM, so an in-flight instruction can complete.
  // - S_LDR: the loader drives the RAM and CPU strobes are ignored.
  // - S_TURN: nothing writes.
  always_comb begin
    w_ram_addr  = bus.cpu_addr;
    w_ram_we    = bus.cpu_ram_in;
    w_ram_wdata = bus.cpu_wdata;
    case (r_state)
      S_LDR: begin
        w_ram_addr  = bus.ldr_addr;
        w_ram_we    = bus.ldr_valid && bus.ldr_we;
        w_ram_wdata = bus.ldr_wdata;
      end
      S_TURN: begin
        w_ram_we    = 1'b0;
      end
      default: begin
        w_ram_we    = bus.cpu_ram_in;
      end
    endcase
  end

  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_wdata = w_ram_wdata;

  // State register plus the stall and grant flags.
  // Both flags are decoded from the next state, so they are glitch-free and valid from
  // the first cycle in each state.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      r_state <= S_CPU;
      r_stall <= 1'b0;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stall <= (w_next != S_CPU);
      r_gnt   <= (w_next == S_LDR);
    end
  end

  // Burst counter, the forced-release flag and the fairness flag.
  // Together they guarantee that the CPU runs at least one instruction between
  // forced loader bursts.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      r_burst_cnt <= '0;
      r_fair      <= 1'b0;
      r_forced    <= 1'b0;
    end else begin
      case (r_state)
        S_CPU: begin
          // The first cycle away from T0 means the CPU has started an instruction.
          if (r_fair && !bus.cpu_t0) begin
            r_fair <= 1'b0;
          end
        end
        S_LDR: begin
          r_burst_cnt <= w_cnt_next;
          if (w_next == S_TURN) begin
            r_forced <= w_limit && bus.ldr_req;
          end
        end
        S_TURN: begin
          r_burst_cnt <= '0;
          r_fair      <= r_forced;
          r_forced    <= 1'b0;
        end
        default: begin
          r_burst_cnt <= r_burst_cnt;
        end
      endcase
    end
  end

  // Beat completion: the ack pulses for one cycle, and the read data is captured
  // alongside it.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_beat;
      if (w_beat) begin
        r_rdata <= bus.ram_rdata;
      end
    end
  end

  assign bus.cpu_stall = r_stall;
  assign bus.ldr_gnt   = r_gnt;
  assign bus.ldr_ack   = r_ack;
  assign bus.ldr_rdata = r_rdata;

`ifdef RAM_ARB_ERR_EN
  // Sticky protocol checker. It flags either of two conditions:
  // - a loader beat offered without a grant;
  // - a CPU write strobe while the loader owns the RAM.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      r_err <= 1'b0;
    end else if ((bus.ldr_valid && !r_gnt) || (bus.cpu_ram_in && (r_state == S_LDR))) begin
      r_err <= 1'b1;
    end
  end
`else
  // Checker not built: the error flag is a constant.
  assign r_err = 1'b0;
`endif

  assign bus.arb_err = r_err;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter.
// A small RAM model hangs off the interface. Every expected value below is hand-derived
// from the arbiter's intended behaviour. Build with RAM_ARB_ERR_EN defined to exercise
// the protocol checker.
module tb_ram_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

`ifdef RAM_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clock;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(4)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  // Clock: the active edge is the falling one.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: asynchronous read, write on the falling edge.
  // Location i is preloaded with 0x10+i.
  logic [DATA_W-1:0] mem [16];
  bit                mem_loaded = 1'b0;

  always @(negedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      mem_loaded <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  assign bus.ram_rdata = mem[bus.ram_addr];

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge, then wait 1 time unit so registered outputs settle.
  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  initial begin
    clear          = 1'b0;
    bus.cpu_t0     = 1'b0;
    bus.cpu_hlt    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_ram_in = 1'b0;
    bus.cpu_wdata  = '0;
    bus.ldr_req    = 1'b0;
    bus.ldr_valid  = 1'b0;
    bus.ldr_we     = 1'b0;
    bus.ldr_addr   = '0;
    bus.ldr_wdata  = '0;

    // Reset state
    #23;
    check("rst_stall", bus.cpu_stall, 0);
    check("rst_gnt",   bus.ldr_gnt,   0);
    check("rst_ack",   bus.ldr_ack,   0);
    check("rst_rdata", bus.ldr_rdata, 0);
    check("rst_err",   bus.arb_err,   0);
    clear = 1'b1;
    cyc();

    // CPU write passes straight through the mux in S_CPU
    bus.cpu_addr = 4'd5; bus.cpu_wdata = 8'h5C; bus.cpu_ram_in = 1'b1;
    #1;
    check("cpu_we",    bus.ram_we,    1);
    check("cpu_addr",  bus.ram_addr,  5);
    check("cpu_wdata", bus.ram_wdata, 8'h5C);
    cyc();
    check("cpu_mem5", mem[5], 8'h5C);
    bus.cpu_ram_in = 1'b0;

    // Request while the CPU is at T1: stall first, grant only once T0 is reached
    bus.cpu_t0 = 1'b0; bus.ldr_req = 1'b1; bus.cpu_addr = 4'd6;
    cyc();
    check("drain_stall", bus.cpu_stall, 1);
    check("drain_gnt",   bus.ldr_gnt,   0);
    bus.cpu_ram_in = 1'b1; bus.cpu_wdata = 8'h66;
    #1;
    check("drain_cpu_we",   bus.ram_we,   1);
    check("drain_cpu_addr", bus.ram_addr, 6);
    cyc();
    check("drain_mem6",   mem[6],      8'h66);
    check("drain_gnt2",   bus.ldr_gnt, 0);
    bus.cpu_ram_in = 1'b0; bus.cpu_t0 = 1'b1;
    cyc();
    check("grant_gnt",   bus.ldr_gnt,   1);
    check("grant_stall", bus.cpu_stall, 1);

    // Loader writes 0xA5 to address 3, then reads it back
    bus.ldr_valid = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 4'd3; bus.ldr_wdata = 8'hA5;
    #1;
    check("ldr_we",    bus.ram_we,    1);
    check("ldr_addr",  bus.ram_addr,  3);
    check("ldr_wdata", bus.ram_wdata, 8'hA5);
    cyc();
    check("wr_ack",  bus.ldr_ack, 1);
    check("wr_mem3", mem[3],      8'hA5);
    bus.ldr_we = 1'b0;
    cyc();
    check("rd_ack",   bus.ldr_ack,   1);
    check("rd_rdata", bus.ldr_rdata, 8'hA5);
    bus.ldr_valid = 1'b0;
    cyc();
    check("idle_ack", bus.ldr_ack, 0);
    check("idle_gnt", bus.ldr_gnt, 1);

    // A CPU strobe during S_LDR never reaches the RAM
    bus.cpu_ram_in = 1'b1; bus.cpu_addr = 4'd3; bus.cpu_wdata = 8'h00;
    #1;
    check("strobe_we", bus.ram_we, 0);
    cyc();
    check("strobe_mem3", mem[3],      8'hA5);
    check("strobe_err",  bus.arb_err, ERR_EXP);
    bus.cpu_ram_in = 1'b0;

    // Voluntary release: S_TURN, then back to S_CPU with fairness not set
    bus.ldr_req = 1'b0;
    cyc();
    check("turn_gnt",   bus.ldr_gnt,   0);
    check("turn_stall", bus.cpu_stall, 1);
    cyc();
    check("back_stall", bus.cpu_stall, 0);

    // Forced release after MAX_BURST=4 beats with the CPU running
    bus.cpu_t0 = 1'b1; bus.cpu_hlt = 1'b0; bus.ldr_req = 1'b1;
    cyc();
    check("b4_drain", bus.cpu_stall, 1);
    cyc();
    check("b4_gnt", bus.ldr_gnt, 1);
    bus.ldr_valid = 1'b1; bus.ldr_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ldr_addr  = 4'(8 + i);
      bus.ldr_wdata = 8'h80 + 8'(i);
      cyc();
      check("b4_ack", bus.ldr_ack, 1);
    end
    bus.ldr_valid = 1'b0;
    check("b4_turn_gnt",   bus.ldr_gnt,   0);
    check("b4_turn_stall", bus.cpu_stall, 1);
    #1;
    check("b4_turn_we", bus.ram_we, 0);
    check("b4_mem8",  mem[8],  8'h80);
    check("b4_mem11", mem[11], 8'h83);
    cyc();
    check("b4_cpu_stall", bus.cpu_stall, 0);
    check("b4_cpu_ack",   bus.ldr_ack,   0);
    cyc();
    check("fair_hold_stall", bus.cpu_stall, 0);
    bus.cpu_t0 = 1'b0;  // CPU leaves T0 to run one instruction
    cyc();
    check("fair_clear_stall", bus.cpu_stall, 0);
    cyc();
    check("regrant_drain", bus.cpu_stall, 1);
    check("regrant_gnt0",  bus.ldr_gnt,   0);
    bus.cpu_t0 = 1'b1;
    cyc();
    check("regrant_gnt", bus.ldr_gnt, 1);

    // Halted CPU: 16 beats without a forced release
    bus.cpu_hlt = 1'b1; bus.ldr_valid = 1'b1; bus.ldr_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.ldr_addr  = 4'(i);
      bus.ldr_wdata = 8'h40 + 8'(i);
      cyc();
      check("hlt_ack", bus.ldr_ack, 1);
      check("hlt_gnt", bus.ldr_gnt, 1);
    end
    bus.ldr_valid = 1'b0;
    check("hlt_cnt_sat", dut.r_burst_cnt, 4);
    check("hlt_mem0",  mem[0],  8'h40);
    check("hlt_mem15", mem[15], 8'h4F);
    bus.ldr_req = 1'b0; bus.cpu_hlt = 1'b0;
    cyc();
    check("hlt_turn_gnt", bus.ldr_gnt, 0);
    cyc();
    check("hlt_back_stall", bus.cpu_stall, 0);
    check("hlt_fair",       dut.r_fair,    0);

    // Reset in the middle of a burst, during beat 2
    bus.ldr_req = 1'b1;
    cyc();
    cyc();
    check("mid_gnt", bus.ldr_gnt, 1);
    bus.ldr_valid = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 4'd2; bus.ldr_wdata = 8'h21;
    cyc();
    check("mid_ack1", bus.ldr_ack, 1);
    bus.ldr_addr = 4'd4; bus.ldr_wdata = 8'h99;
    #1;
    clear = 1'b0;
    #1;
    check("mid_rst_stall", bus.cpu_stall, 0);
    check("mid_rst_gnt",   bus.ldr_gnt,   0);
    check("mid_rst_ack",   bus.ldr_ack,   0);
    check("mid_rst_rdata", bus.ldr_rdata, 0);
    check("mid_rst_err",   bus.arb_err,   0);
    check("mid_rst_we",    bus.ram_we,    0);
    check("mid_rst_state", dut.r_state,   0);
    bus.ldr_valid = 1'b0; bus.ldr_req = 1'b0;
    cyc();
    check("mid_rst_mem4", mem[4], 8'h44);
    check("mid_rst_mem2", mem[2], 8'h21);
    clear = 1'b1;
    cyc();
    check("post_rst_state", dut.r_state,     0);
    check("post_rst_cnt",   dut.r_burst_cnt, 0);
    check("post_rst_gnt",   bus.ldr_gnt,     0);

    // A beat offered without a grant is dropped, and the error flag is sticky
    bus.ldr_valid = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 4'd1; bus.ldr_wdata = 8'hDD;
    bus.cpu_addr = 4'd7;
    #1;
    check("drop_we",   bus.ram_we,   0);
    check("drop_addr", bus.ram_addr, 7);
    cyc();
    check("drop_ack", bus.ldr_ack, 0);
    check("drop_mem", mem[1],      8'h41);
    check("err_set",  bus.arb_err, ERR_EXP);
    bus.ldr_valid = 1'b0;
    cyc();
    cyc();
    check("err_sticky", bus.arb_err, ERR_EXP);
    clear = 1'b0;
    #1;
    check("err_cleared", bus.arb_err, 0);
    clear = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_arbiter
